blink_sequencer: RTL and testbench
==================================

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- LED_W, 4, LED vector width; legal range 2..8.
- PASSES, 2, number of full pattern passes per run; legal range 1..255.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clkin, in, 1, the only clock; all logic on its rising edge.
- rstn, in, 1, synchronous active-low reset.
- slow_clk, in, 1, divided clock from the upstream divider, treated as asynchronous data.
- start, in, 1, level; requests a run when sampled high in IDLE.
- stop, in, 1, level; aborts a run.
- mode, in, 2, pattern select; latched at start.
- led, out, LED_W, registered pattern output.
- busy, out, 1, registered; high in RUN.
- done, out, 1, registered; one-cycle pulse at normal run completion.

Function
REQ-003 slow_clk SHALL pass through a 2-flop synchroniser (s1, s2) followed by a history flop s3.
REQ-004 Internal tick SHALL be s2 AND NOT s3, giving exactly one tick per slow_clk rising edge, independent of the high-time.
REQ-005 FSM states SHALL be IDLE, RUN and DONE.
REQ-006 IDLE behaviour:
- led=0, busy=0, done=0.
- start=1 and stop=0 -> RUN on the next edge; latch mode; step=0, pass=0; led=initial pattern; busy=1.
REQ-007 Patterns (L = steps per pass; step k drives):
- mode 0, blink: L=2; all-ones, all-zeros.
- mode 1, chase: L=LED_W; one-hot 1<<k.
- mode 2, ping-pong: L=2*LED_W-2; 1<<k for k<LED_W, else 1<<(2*LED_W-2-k).
- mode 3, count: L=2^LED_W; binary k.
REQ-008 In RUN, each tick SHALL advance:
- step+1 with led updated on the same edge.
- At step=L-1, step wraps to 0 and pass increments.
REQ-009 The tick that completes pass PASSES-1 (the PASSES*L-th tick) SHALL move to DONE with led=0, busy=0, done=1.
REQ-010 DONE SHALL last exactly one cycle, then IDLE with done=0; start in DONE is ignored.
REQ-011 stop=1 in RUN SHALL go to IDLE on the next edge with led=0 and busy=0, and no done pulse.
REQ-012 Priorities:
- stop beats a same-cycle tick.
- stop beats start in IDLE; stays IDLE.
- start in RUN is ignored.
- mode changes during RUN are ignored.
- A tick in IDLE, or in the same cycle as the start that leaves IDLE, does not advance the step.
REQ-013 Tick-to-led latency SHALL be 3 clkin edges after the slow_clk rise at the s1 sampling edge; led changes on the edge where tick=1.
REQ-014 The step counter SHALL be wide enough for 2^LED_W-1; the pass counter SHALL be 8 bits, with no overflow for legal PASSES.

Reset
REQ-015 rstn=0 at any clkin edge, including mid-RUN, SHALL force on that edge:
- state=IDLE, led=0, busy=0, done=0.
- step=0, pass=0, s1=s2=s3=0.
REQ-016 The first tick after reset release SHALL require a new slow_clk rising edge, so no spurious tick occurs if slow_clk is already high.

Verification (LED_W=4, PASSES=2)
REQ-017 Chase: mode=1, start.
- led=0001 on start; 8 ticks give 0010, 0100, 1000, 0001, 0010, 0100, 1000, then DONE.
- done=1 for one cycle and led=0000 on the 8th tick.
REQ-018 Ping-pong: mode=2; 12 ticks give 0010, 0100, 1000, 0100, 0010, 0001 twice (last replaced by DONE) -> done after the 12th tick.
REQ-019 Count: mode=3, initial 0000; led equals the tick count mod 16; done on the 32nd tick; blink mode=0 done on the 4th tick.
REQ-020 Abort: stop and tick asserted in the same cycle during RUN -> next edge led=0000, busy=0, done stays 0, led does not advance.
REQ-021 Reset: rstn=0 mid-run with slow_clk held high -> led=0, busy=0 on that edge; after release and a new start, no tick occurs until slow_clk falls and rises again.
REQ-022 Tick integrity:
- slow_clk high for 50 cycles -> exactly one led step.
- start pulsed during RUN -> sequence unchanged.
- mode changed mid-RUN -> pattern unchanged.

Source files
------------

// File: rtl/blink_sequencer.sv
// LED pattern sequencer: steps a selectable pattern once per rising edge of an
// asynchronous slow clock, for a fixed number of passes, then pulses done.
module blink_sequencer #(
  parameter int LED_W  = 4,
  parameter int PASSES = 2
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             slow_clk,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int SW = LED_W;
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [7:0]    PASS_LAST = 8'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_step, w_step_nxt;
  logic [7:0]        r_pass, w_pass_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [LED_W-1:0]  r_led, w_led_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_s1, r_s2, r_s3;
  logic              r_sync_valid, r_armed;
  logic              w_tick;

  function automatic logic [LED_W-1:0] f_pattern(input logic [1:0] m, input logic [SW-1:0] k);
    logic [LED_W-1:0] one;
    logic [LED_W-1:0] p;
    one = {{(LED_W-1){1'b0}}, 1'b1};
    case (m)
      2'd0:    p = (k == {SW{1'b0}}) ? {LED_W{1'b1}} : {LED_W{1'b0}};
      2'd1:    p = one << k;
      2'd2:    p = (k < SW'(LED_W)) ? (one << k) : (one << (SW'(2*LED_W-2) - k));
      2'd3:    p = k;
      default: p = {LED_W{1'b0}};
    endcase
    return p;
  endfunction

  function automatic logic [SW-1:0] f_last_step(input logic [1:0] m);
    logic [SW-1:0] l;
    case (m)
      2'd0:    l = SW'(1);
      2'd1:    l = SW'(LED_W - 1);
      2'd2:    l = SW'(2*LED_W - 3);
      2'd3:    l = {SW{1'b1}};
      default: l = SW'(1);
    endcase
    return l;
  endfunction

  // Synchroniser plus history flop; arming needs a real low sample after reset
  // so a slow_clk that is already high cannot produce a tick.
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_sync_valid <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_s1         <= slow_clk;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_sync_valid <= 1'b1;
      r_armed      <= r_armed | (r_sync_valid & ~r_s1);
    end
  end

  assign w_tick = r_s2 & ~r_s3 & r_armed;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_pass_nxt  = r_pass;
    w_mode_nxt  = r_mode;
    w_led_nxt   = r_led;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_led_nxt  = {LED_W{1'b0}};
        w_busy_nxt = 1'b0;
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_mode_nxt  = mode;
          w_step_nxt  = {SW{1'b0}};
          w_pass_nxt  = 8'd0;
          w_led_nxt   = f_pattern(mode, {SW{1'b0}});
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_step_nxt  = {SW{1'b0}};
          w_pass_nxt  = 8'd0;
          w_led_nxt   = {LED_W{1'b0}};
          w_busy_nxt  = 1'b0;
        end else if (w_tick) begin
          if (r_step == f_last_step(r_mode)) begin
            w_step_nxt = {SW{1'b0}};
            if (r_pass == PASS_LAST) begin
              w_state_nxt = S_DONE;
              w_pass_nxt  = 8'd0;
              w_led_nxt   = {LED_W{1'b0}};
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_pass_nxt = r_pass + 8'd1;
              w_led_nxt  = f_pattern(r_mode, {SW{1'b0}});
            end
          end else begin
            w_step_nxt = r_step + STEP_ONE;
            w_led_nxt  = f_pattern(r_mode, r_step + STEP_ONE);
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_led_nxt   = {LED_W{1'b0}};
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = {SW{1'b0}};
        w_pass_nxt  = 8'd0;
        w_led_nxt   = {LED_W{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_step  <= {SW{1'b0}};
      r_pass  <= 8'd0;
      r_mode  <= 2'd0;
      r_led   <= {LED_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_pass  <= w_pass_nxt;
      r_mode  <= w_mode_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer (LED_W=4, PASSES=2) with a queue of
// expected output snapshots compared as the DUT produces them.
module tb_blink_sequencer;

  logic       clkin = 1'b0;
  logic       rstn = 1'b0;
  logic       slow_clk = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] led;
  logic       busy;
  logic       done;

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  blink_sequencer #(.LED_W(4), .PASSES(2)) dut (
    .clkin(clkin), .rstn(rstn), .slow_clk(slow_clk), .start(start),
    .stop(stop), .mode(mode), .led(led), .busy(busy), .done(done)
  );

  always #5 clkin = ~clkin;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk();
    @(posedge clkin);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] l, input logic b, input logic d);
    exp_t e;
    e.tag = tag; e.led = l; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [5:0] obs, want;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed no entry, expected one");
      return;
    end
    e = sb.pop_front();
    obs  = {led, busy, done};
    want = {e.led, e.busy, e.done};
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed led=%b busy=%b done=%b, expected led=%b busy=%b done=%b",
             e.tag, led, busy, done, e.led, e.busy, e.done);
    end
  endtask

  // Expected LED value n ticks after start, taken from the pattern tables.
  function automatic logic [3:0] exp_led(input logic [1:0] m, input int n);
    logic [3:0] v;
    case (m)
      2'd0: v = ((n % 2) == 0) ? 4'hF : 4'h0;
      2'd1: v = 4'b0001 << (n % 4);
      2'd2: begin
        case (n % 6)
          0: v = 4'b0001;
          1: v = 4'b0010;
          2: v = 4'b0100;
          3: v = 4'b1000;
          4: v = 4'b0100;
          default: v = 4'b0010;
        endcase
      end
      default: v = 4'(n % 16);
    endcase
    return v;
  endfunction

  task automatic do_tick(input string tag, input logic [3:0] l);
    slow_clk = 1'b1;
    clk(); clk(); clk();
    push(tag, l, 1'b1, 1'b0);
    check();
    slow_clk = 1'b0;
    clk(); clk(); clk();
  endtask

  task automatic run_pattern(input logic [1:0] m, input int len, input string tag);
    mode = m; start = 1'b1;
    clk();
    start = 1'b0;
    push({tag, "_start"}, exp_led(m, 0), 1'b1, 1'b0);
    check();
    for (int n = 1; n <= 2*len; n++) begin
      slow_clk = 1'b1;
      clk(); clk(); clk();
      if (n < 2*len) push({tag, "_step"}, exp_led(m, n), 1'b1, 1'b0);
      else           push({tag, "_done"}, 4'h0, 1'b0, 1'b1);
      check();
      if (n == 2*len) start = 1'b1;
      slow_clk = 1'b0;
      clk();
      if (n == 2*len) begin
        start = 1'b0;
        push({tag, "_done_end"}, 4'h0, 1'b0, 1'b0);
        check();
      end
      clk(); clk();
    end
    clk();
    push({tag, "_idle"}, 4'h0, 1'b0, 1'b0);
    check();
  endtask

  initial begin
    #1;
    clk(); clk();
    push("reset", 4'h0, 1'b0, 1'b0);
    check();
    rstn = 1'b1;
    clk(); clk(); clk();

    start = 1'b1; stop = 1'b1;
    clk();
    start = 1'b0; stop = 1'b0;
    push("stop_beats_start", 4'h0, 1'b0, 1'b0);
    check();

    run_pattern(2'd1, 4,  "chase");
    run_pattern(2'd2, 6,  "pingpong");
    run_pattern(2'd3, 16, "count");
    run_pattern(2'd0, 2,  "blink");

    // Abort with stop and tick in the same cycle.
    mode = 2'd1; start = 1'b1;
    clk();
    start = 1'b0;
    push("abort_start", 4'b0001, 1'b1, 1'b0);
    check();
    do_tick("abort_tick1", 4'b0010);
    slow_clk = 1'b1;
    clk(); clk();
    stop = 1'b1;
    clk();
    stop = 1'b0;
    push("abort_stop", 4'h0, 1'b0, 1'b0);
    check();
    slow_clk = 1'b0;
    clk(); clk(); clk();
    push("abort_no_done", 4'h0, 1'b0, 1'b0);
    check();

    // Start in the cycle a tick is present: the tick must not advance.
    slow_clk = 1'b1;
    clk(); clk();
    mode = 2'd1; start = 1'b1;
    clk();
    start = 1'b0;
    push("start_with_tick", 4'b0001, 1'b1, 1'b0);
    check();
    clk();
    push("start_with_tick_hold", 4'b0001, 1'b1, 1'b0);
    check();
    slow_clk = 1'b0;
    clk(); clk(); clk();

    // Long high time gives a single step.
    slow_clk = 1'b1;
    clk(); clk(); clk();
    push("long_high_step", 4'b0010, 1'b1, 1'b0);
    check();
    repeat (47) clk();
    push("long_high_hold", 4'b0010, 1'b1, 1'b0);
    check();
    slow_clk = 1'b0;
    clk(); clk(); clk();

    // Start pulse and mode change during RUN are ignored.
    start = 1'b1;
    clk();
    start = 1'b0;
    push("start_in_run", 4'b0010, 1'b1, 1'b0);
    check();
    mode = 2'd3;
    do_tick("mode_change_1", 4'b0100);
    do_tick("mode_change_2", 4'b1000);

    // Reset mid-run with slow_clk held high.
    slow_clk = 1'b1;
    clk(); clk(); clk();
    push("pre_reset_wrap", 4'b0001, 1'b1, 1'b0);
    check();
    rstn = 1'b0;
    clk();
    push("mid_run_reset", 4'h0, 1'b0, 1'b0);
    check();
    rstn = 1'b1; mode = 2'd1; start = 1'b1;
    clk();
    start = 1'b0;
    push("restart", 4'b0001, 1'b1, 1'b0);
    check();
    repeat (10) clk();
    push("no_spurious_tick", 4'b0001, 1'b1, 1'b0);
    check();
    slow_clk = 1'b0;
    clk(); clk(); clk();
    do_tick("first_real_tick", 4'b0010);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
